alu_seq: RTL

Parametrised-width ALU for the CPU datapath, extending the single-cycle op set with an iterative unsigned multiplier and divider behind a valid/ready handshake. It sits between the register-file read stage and write-back. Single-cycle ops return one cycle after acceptance. MUL/DIVU/REMU hold the unit busy for a fixed WIDTH-cycle iteration, and the control unit stalls on `ready_o`.

---
 rtl/alu_seq_if.sv | 24 ++
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-read stage and alu_seq.
// master drives operands and the op request; slave returns the registered result.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             valid_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;

  modport master (
    output valid_i, ctrl_i, src1_i, src2_i,
    input  ready_o, valid_o, result_o, zero_o
  );

  modport slave (
    input  valid_i, ctrl_i, src1_i, src2_i,
    output ready_o, valid_o, result_o, zero_o
  );
endinterface

// File: rtl/alu_seq.sv
// Datapath ALU: single-cycle logic/arith ops plus an iterative shift-add multiplier.
// Define ALU_SEQ_DIV_EN to build the restoring divider for DIVU/REMU.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk_i,
  input  logic     rst_i,
  alu_seq_if.slave bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_LUI  = 4'd9;
  localparam logic [3:0] OP_SLE  = 4'd11;
  localparam logic [3:0] OP_NOR  = 4'd12;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'd4;
  localparam logic [3:0] OP_REMU = 4'd5;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // product accumulator / partial remainder
  logic [WIDTH-1:0] opa_q, opa_d;     // multiplicand / dividend shifting into quotient
  logic [WIDTH-1:0] opb_q, opb_d;     // multiplier / divisor
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
`ifdef ALU_SEQ_DIV_EN
  logic             div_q, div_d;
  logic             rem_q, rem_d;
  logic [WIDTH:0]   rem_sh_c;
  logic             ge_c;
`endif

  logic             accept_c;
  logic             is_iter_c;
  logic [WIDTH-1:0] alu_c;

  assign accept_c     = bus.valid_i && ready_q;
  assign bus.ready_o  = ready_q;
  assign bus.valid_o  = valid_q;
  assign bus.result_o = result_q;
  assign bus.zero_o   = zero_q;

  // Single-cycle result and iterative-op decode
  always_comb begin
    alu_c     = '0;
    is_iter_c = 1'b0;
    case (bus.ctrl_i)
      OP_AND: alu_c = bus.src1_i & bus.src2_i;
      OP_OR:  alu_c = bus.src1_i | bus.src2_i;
      OP_ADD: alu_c = bus.src1_i + bus.src2_i;
      OP_SUB: alu_c = bus.src1_i - bus.src2_i;
      OP_NOR: alu_c = ~(bus.src1_i | bus.src2_i);
      OP_SLT: alu_c = WIDTH'($signed(bus.src1_i) <  $signed(bus.src2_i));
      OP_SLE: alu_c = WIDTH'($signed(bus.src1_i) <= $signed(bus.src2_i));
      OP_SRA: alu_c = $unsigned($signed(bus.src2_i) >>> bus.src1_i[SHW-1:0]);
      OP_LUI: alu_c = bus.src2_i << (WIDTH / 2);
      OP_MUL: is_iter_c = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      OP_DIVU, OP_REMU: is_iter_c = 1'b1;
`endif
      default: alu_c = '0;
    endcase
  end

`ifdef ALU_SEQ_DIV_EN
  // Restoring step: bring in next dividend bit, subtract divisor if it fits
  always_comb begin
    rem_sh_c = {acc_q, opa_q[WIDTH-1]};
    ge_c     = (rem_sh_c >= {1'b0, opb_q});
  end
`endif

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
`ifdef ALU_SEQ_DIV_EN
    div_d    = div_q;
    rem_d    = rem_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept_c) begin
          if (is_iter_c) begin
            state_d = ST_RUN;
            cnt_d   = SHW'(WIDTH - 1);
            acc_d   = '0;
            opa_d   = bus.src1_i;
            opb_d   = bus.src2_i;
`ifdef ALU_SEQ_DIV_EN
            div_d   = (bus.ctrl_i == OP_DIVU) || (bus.ctrl_i == OP_REMU);
            rem_d   = (bus.ctrl_i == OP_REMU);
`endif
          end else begin
            state_d  = ST_DONE;
            result_d = alu_c;
          end
        end
      end
      ST_RUN: begin
        acc_d = acc_q + (opb_q[0] ? opa_q : '0);
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
`ifdef ALU_SEQ_DIV_EN
        if (div_q) begin
          opa_d = {opa_q[WIDTH-2:0], ge_c};
          opb_d = opb_q;
          acc_d = ge_c ? WIDTH'(rem_sh_c - {1'b0, opb_q}) : rem_sh_c[WIDTH-1:0];
        end
`endif
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          result_d = acc_d;
`ifdef ALU_SEQ_DIV_EN
          if (div_q && !rem_q) result_d = opa_d;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    zero_d  = (result_d == '0);
    valid_d = (state_d == ST_DONE);
    ready_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
      div_q    <= 1'b0;
      rem_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
`ifdef ALU_SEQ_DIV_EN
      div_q    <= div_d;
      rem_q    <= rem_d;
`endif
    end
  end

endmodule
